data_memory_sized: RTL and testbench
====================================

Name: data_memory_sized

Overview:
Byte-addressed, big-endian data memory for the pipeline's MEM stage, with a request/done handshake.
- Supports byte, halfword and word loads and stores.
- Loads are sign- or zero-extended.
- Detects misaligned and out-of-range accesses.
- Adds a parametrised access latency to model slower memory.
- Replaces the fixed 32-byte, word-only, combinational-read data memory.

Parameters:
DEPTH_BYTES, 1024, memory size in bytes; power of two, at least 4.
LATENCY, 1, cycles from request acceptance to done_o; range 1..15.
ADDR_W, 32, width of addr_i.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  reset, synchronous, active-high.
req_i  in  1  access request; sampled only while ready_o=1.
we_i  in  1  1=store, 0=load; sampled with req_i.
size_i  in  2  00=byte, 01=half, 10=word, 11=reserved.
unsigned_i  in  1  load extension: 1=zero-extend, 0=sign-extend; ignored for word and stores.
addr_i  in  ADDR_W  byte address.
wdata_i  in  32  store data; low-order bytes are used for byte/half.
ready_o  out  1  block idle and able to accept a request.
done_o  out  1  one-cycle completion pulse.
err_o  out  1  valid with done_o: access was misaligned, out of range or of reserved size.
rdata_o  out  32  load result; updated only on a successful load completion, held otherwise.

Behaviour:
- Reset (rst_i=1 at clock edge): state=IDLE, ready_o=1, done_o=0, err_o=0, rdata_o=0, counter=0. Any in-flight access is aborted and its pending write is discarded. Memory contents are not reset.
- FSM states:
  - IDLE: ready_o=1.
  - WAIT: ready_o=0.
  - DONE: ready_o=0, done_o=1.
- Acceptance: req_i=1 in IDLE at an edge captures we_i, size_i, unsigned_i, addr_i and wdata_i into request registers. Inputs are don't-care afterwards.
  - LATENCY=1: next state is DONE.
  - LATENCY>1: next state is WAIT with counter=LATENCY-1.
- WAIT: counter decrements each cycle; on the edge where counter==1, next state is DONE.
- Commit edge (the edge entering DONE):
  - Store: memory updated.
  - Load: rdata_o and err_o registered.
- DONE lasts exactly one cycle, then IDLE.
- Timing: done_o is high exactly LATENCY cycles after the acceptance cycle. Peak throughput is one access per LATENCY+1 cycles.
- Error conditions, evaluated on the captured request:
  - size=01 with addr[0]=1.
  - size=10 with addr[1:0]!=0.
  - size=11.
  - addr+bytes-1 >= DEPTH_BYTES.
- On error: no memory change, rdata_o held, err_o=1 with done_o. Latency is unchanged.
- Byte order is big-endian: mem[a] is the most significant byte.
  - Byte load: mem[a].
  - Half load: {mem[a],mem[a+1]}.
  - Word load: {mem[a],mem[a+1],mem[a+2],mem[a+3]}.
- Extension: byte/half are extended to 32 bits per unsigned_i.
- Stores:
  - Byte writes wdata[7:0] to mem[a].
  - Half writes wdata[15:0] to mem[a..a+1].
  - Word writes all 4 bytes.
  - Only the addressed bytes change.
- Only addr[log2(DEPTH_BYTES)-1:0] indexes memory; upper bits participate only in the range check.
- Store followed by a load to the same address returns the stored data, since the store commits before the load is accepted.
- req_i while not ready is ignored (no queueing). The requester must hold req_i until ready_o=1.
- err_o and done_o are low outside DONE.

Decomposition:
- Package data_mem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD.
  - FSM state typedef {IDLE, WAIT, DONE}.
  - function size_bytes(size).
- Sub-module data_mem_load_ext: combinational. Selects bytes for a size and extends them. Inputs: raw 32-bit big-endian word read at addr, size, unsigned. Output: 32-bit result.

Test Plan:
- Reset then word store 0xDEADBEEF @0x10, then word load @0x10, LATENCY=1. Each op has done_o in the cycle after acceptance; load gives rdata_o=0xDEADBEEF, err_o=0.
- After the above: byte load @0x10 signed gives 0xFFFFFFDE; unsigned gives 0x000000DE; half load @0x12 signed gives 0xFFFFBEEF.
- Byte store 0x55 @0x11, then word load @0x10 gives 0xDE55BEEF (other bytes untouched).
- Half load @0x13 gives err_o=1, rdata_o held at previous value. Word store @0x3FE with DEPTH_BYTES=1024 gives err_o=1 and memory unchanged. size_i=11 gives err_o=1.
- LATENCY=4: load accepted at cycle 0 gives ready_o=0 for cycles 1-4 and done_o only in cycle 4. A req_i pulse at cycle 2 is ignored (no extra done_o).
- Store accepted, then rst_i at cycle 1 of LATENCY=3: no done_o, ready_o=1 after reset, and a subsequent load of that address returns its pre-store contents.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared encodings and helpers for the sized, big-endian data memory.
package data_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t WAIT = 2'd1;
    localparam state_t DONE = 2'd2;

    // Reserved size reports 4 bytes; it is flagged as an error anyway.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_load_ext.sv
// Picks the leading bytes of a big-endian word for the access size and extends them.
module data_mem_load_ext
    import data_mem_pkg::*;
(
    input  logic [31:0] raw_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] result_o
);

    always_comb begin
        result_o = raw_i;
        case (size_i)
            SZ_BYTE: result_o = {{24{~unsigned_i & raw_i[31]}}, raw_i[31:24]};
            SZ_HALF: result_o = {{16{~unsigned_i & raw_i[31]}}, raw_i[31:16]};
            default: result_o = raw_i;
        endcase
    end

endmodule

// File: rtl/data_memory_sized.sv
// Byte-addressed big-endian data memory with request/done handshake and fixed access latency.
// Handshake: a request is taken when req_i=1 while ready_o=1; done_o pulses LATENCY cycles later.
module data_memory_sized
    import data_mem_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              ready_o,
    output logic              done_o,
    output logic              err_o,
    output logic [31:0]       rdata_o
);

    localparam int IDX_W = $clog2(DEPTH_BYTES);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [7:0]        mem [DEPTH_BYTES];

    logic              commit;
    logic              cur_we, cur_uns, cur_err;
    logic [1:0]        cur_size;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       cur_wdata;
    logic [IDX_W-1:0]  idx;
    logic [2:0]        nbytes;
    logic [ADDR_W:0]   last_addr;
    logic [31:0]       raw_word, load_val, store_word;
    logic [3:0]        lane_we;

    // With LATENCY=1 the commit edge is the acceptance edge, so the live inputs are used there.
    always_comb begin
        cur_we    = (state_q == IDLE) ? we_i       : we_q;
        cur_size  = (state_q == IDLE) ? size_i     : size_q;
        cur_uns   = (state_q == IDLE) ? unsigned_i : uns_q;
        cur_addr  = (state_q == IDLE) ? addr_i     : addr_q;
        cur_wdata = (state_q == IDLE) ? wdata_i    : wdata_q;
        idx       = cur_addr[IDX_W-1:0];
        nbytes    = size_bytes(cur_size);
        last_addr = {1'b0, cur_addr} + (ADDR_W+1)'(nbytes) - (ADDR_W+1)'(1);
        cur_err   = (cur_size == SZ_RSVD)
                  | ((cur_size == SZ_HALF) & cur_addr[0])
                  | ((cur_size == SZ_WORD) & (cur_addr[1:0] != 2'b00))
                  | (last_addr >= (ADDR_W+1)'(DEPTH_BYTES));
    end

    always_comb begin
        raw_word = '0;
        for (int i = 0; i < 4; i++) begin
            raw_word[31-8*i -: 8] = mem[idx + IDX_W'(i)];
        end
    end

    data_mem_load_ext u_load_ext (
        .raw_i      (raw_word),
        .size_i     (cur_size),
        .unsigned_i (cur_uns),
        .result_o   (load_val)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    size_d  = size_i;
                    uns_d   = unsigned_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    if (LATENCY == 1) begin
                        state_d = DONE;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                    commit  = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (commit) begin
            err_d = cur_err;
            if (!cur_we && !cur_err) begin
                rdata_d = load_val;
            end
        end
    end

    // Store data is left-justified so lane 0 always lands on the addressed byte.
    always_comb begin
        case (cur_size)
            SZ_BYTE: store_word = {cur_wdata[7:0], 24'h0};
            SZ_HALF: store_word = {cur_wdata[15:0], 16'h0};
            default: store_word = cur_wdata;
        endcase
        lane_we = '0;
        for (int i = 0; i < 4; i++) begin
            lane_we[i] = commit & cur_we & ~cur_err & ~rst_i & (3'(i) < nbytes);
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (lane_we[i]) begin
                mem[idx + IDX_W'(i)] <= store_word[31-8*i -: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        we_q    <= we_d;
        size_q  <= size_d;
        uns_q   <= uns_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    assign ready_o = (state_q == IDLE);
    assign done_o  = (state_q == DONE);
    assign err_o   = done_o & err_q;
    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_data_memory_sized.sv
// Bench for data_memory_sized: three instances (LATENCY 1, 4, 3) against a byte-array reference model.
module tb_data_memory_sized;

    localparam int DEPTH = 1024;
    localparam int NDUT  = 3;
    localparam int LAT_TAB [NDUT] = '{1, 4, 3};

    logic        clk = 1'b0;
    logic        rst   [NDUT];
    logic        req   [NDUT];
    logic        we    [NDUT];
    logic [1:0]  size  [NDUT];
    logic        uns   [NDUT];
    logic [31:0] addr  [NDUT];
    logic [31:0] wdata [NDUT];
    logic        ready [NDUT];
    logic        done  [NDUT];
    logic        err   [NDUT];
    logic [31:0] rdata [NDUT];

    logic [7:0]  ref_mem [NDUT][DEPTH];
    logic [31:0] exp_rdata [NDUT];
    logic [32:0] exp_q [$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_memory_sized #(.DEPTH_BYTES(DEPTH), .LATENCY(1), .ADDR_W(32)) u_lat1 (
        .clk_i(clk), .rst_i(rst[0]), .req_i(req[0]), .we_i(we[0]), .size_i(size[0]),
        .unsigned_i(uns[0]), .addr_i(addr[0]), .wdata_i(wdata[0]), .ready_o(ready[0]),
        .done_o(done[0]), .err_o(err[0]), .rdata_o(rdata[0]));

    data_memory_sized #(.DEPTH_BYTES(DEPTH), .LATENCY(4), .ADDR_W(32)) u_lat4 (
        .clk_i(clk), .rst_i(rst[1]), .req_i(req[1]), .we_i(we[1]), .size_i(size[1]),
        .unsigned_i(uns[1]), .addr_i(addr[1]), .wdata_i(wdata[1]), .ready_o(ready[1]),
        .done_o(done[1]), .err_o(err[1]), .rdata_o(rdata[1]));

    data_memory_sized #(.DEPTH_BYTES(DEPTH), .LATENCY(3), .ADDR_W(32)) u_lat3 (
        .clk_i(clk), .rst_i(rst[2]), .req_i(req[2]), .we_i(we[2]), .size_i(size[2]),
        .unsigned_i(uns[2]), .addr_i(addr[2]), .wdata_i(wdata[2]), .ready_o(ready[2]),
        .done_o(done[2]), .err_o(err[2]), .rdata_o(rdata[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes_of(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit model_err(input logic [1:0] s, input logic [31:0] a);
        int     n    = nbytes_of(s);
        longint last = longint'(a) + longint'(n) - 1;
        return (s == 2'd3) || ((a % n) != 0) || (last >= DEPTH);
    endfunction

    // Reference: plain big-endian byte array, arithmetic sign extension.
    task automatic model_op(input int d, input logic w, input logic [1:0] s, input logic u,
                            input logic [31:0] a, input logic [31:0] wd);
        int     n = nbytes_of(s);
        bit     e = model_err(s, a);
        longint v = 0;
        if (!e) begin
            if (w) begin
                for (int k = 0; k < n; k++) ref_mem[d][a + k] = 8'(wd >> (8 * (n - 1 - k)));
            end else begin
                for (int k = 0; k < n; k++) v = v * 256 + longint'(ref_mem[d][a + k]);
                if (n < 4 && !u && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
                exp_rdata[d] = v[31:0];
            end
        end
        exp_q.push_back({e, exp_rdata[d]});
    endtask

    task automatic do_op(input int d, input logic w, input logic [1:0] s, input logic u,
                         input logic [31:0] a, input logic [31:0] wd);
        int          n = 0;
        logic [32:0] e;
        while (ready[d] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_req", 32'(ready[d]), 32'd1);
        req[d] = 1'b1; we[d] = w; size[d] = s; uns[d] = u; addr[d] = a; wdata[d] = wd;
        model_op(d, w, s, u, a, wd);
        @(posedge clk);
        #1;
        req[d] = 1'b0; we[d] = 1'($urandom); size[d] = 2'($urandom); uns[d] = 1'($urandom);
        addr[d] = $urandom; wdata[d] = $urandom;
        for (int c = 1; c <= LAT_TAB[d]; c++) begin
            @(negedge clk);
            chk("done_timing", 32'(done[d]), 32'(c == LAT_TAB[d]));
            chk("ready_busy", 32'(ready[d]), 32'd0);
            if (c == LAT_TAB[d]) begin
                e = exp_q.pop_front();
                chk("err_at_done", 32'(err[d]), 32'(e[32]));
                chk("rdata_at_done", rdata[d], e[31:0]);
            end else begin
                chk("err_idle_low", 32'(err[d]), 32'd0);
            end
        end
        @(negedge clk);
        chk("ready_after", 32'(ready[d]), 32'd1);
        chk("done_after", 32'(done[d]), 32'd0);
    endtask

    task automatic rand_run(input int d, input int nops);
        logic [31:0] a;
        int          r;
        for (int a0 = 0; a0 < 64; a0 += 4) do_op(d, 1'b1, 2'd2, 1'b0, 32'(a0), $urandom);
        do_op(d, 1'b1, 2'd2, 1'b0, 32'h3FC, $urandom);
        for (int i = 0; i < nops; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7)      a = 32'($urandom_range(0, 63));
            else if (r < 9) a = 32'($urandom_range(1016, 1023));
            else            a = {8'($urandom_range(1, 255)), 24'($urandom_range(0, 63))};
            do_op(d, 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int dones;
        logic [32:0] e;
        for (int d = 0; d < NDUT; d++) begin
            rst[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0; size[d] = 2'd0; uns[d] = 1'b0;
            addr[d] = '0; wdata[d] = '0; exp_rdata[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) rst[d] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            chk("reset_ready", 32'(ready[d]), 32'd1);
            chk("reset_done", 32'(done[d]), 32'd0);
            chk("reset_err", 32'(err[d]), 32'd0);
            chk("reset_rdata", rdata[d], 32'd0);
        end

        // Directed sequence, LATENCY=1
        do_op(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        do_op(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        chk("tp_word_load", rdata[0], 32'hDEADBEEF);
        do_op(0, 1'b0, 2'd0, 1'b0, 32'h10, 32'h0);
        chk("tp_byte_signed", rdata[0], 32'hFFFFFFDE);
        do_op(0, 1'b0, 2'd0, 1'b1, 32'h10, 32'h0);
        chk("tp_byte_unsigned", rdata[0], 32'h000000DE);
        do_op(0, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
        chk("tp_half_signed", rdata[0], 32'hFFFFBEEF);
        do_op(0, 1'b1, 2'd0, 1'b0, 32'h11, 32'hAABBCC55);
        do_op(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        chk("tp_byte_store_merge", rdata[0], 32'hDE55BEEF);
        do_op(0, 1'b0, 2'd1, 1'b0, 32'h13, 32'h0);
        chk("tp_misaligned_held", rdata[0], 32'hDE55BEEF);
        do_op(0, 1'b1, 2'd2, 1'b0, 32'h3FC, 32'h0);
        do_op(0, 1'b1, 2'd2, 1'b0, 32'h0, 32'h11223344);
        do_op(0, 1'b1, 2'd2, 1'b0, 32'h3FE, 32'hCAFEF00D);
        do_op(0, 1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0);
        chk("tp_oob_store_top", rdata[0], 32'h0);
        do_op(0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
        chk("tp_oob_store_wrap", rdata[0], 32'h11223344);
        do_op(0, 1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
        do_op(0, 1'b0, 2'd2, 1'b0, 32'h1000_0010, 32'h0);

        // LATENCY=4: a request pulse while busy must be ignored
        do_op(1, 1'b1, 2'd2, 1'b0, 32'h40, 32'h0BADF00D);
        req[1] = 1'b1; we[1] = 1'b0; size[1] = 2'd2; uns[1] = 1'b0; addr[1] = 32'h40;
        model_op(1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
        @(posedge clk);
        #1;
        req[1] = 1'b0;
        dones = 0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            req[1] = (c == 2);
            if (done[1] === 1'b1) dones++;
            chk("lat4_ready", 32'(ready[1]), 32'(c >= 5));
            chk("lat4_done", 32'(done[1]), 32'(c == 4));
            if (c == 4) begin
                e = exp_q.pop_front();
                chk("lat4_err", 32'(err[1]), 32'(e[32]));
                chk("lat4_rdata", rdata[1], e[31:0]);
            end
        end
        req[1] = 1'b0;
        chk("lat4_single_done", 32'(dones), 32'd1);
        chk("lat4_load_value", rdata[1], 32'h0BADF00D);

        // LATENCY=3: reset during a store aborts it
        do_op(2, 1'b1, 2'd2, 1'b0, 32'h20, 32'hA5A5A5A5);
        req[2] = 1'b1; we[2] = 1'b1; size[2] = 2'd2; uns[2] = 1'b0; addr[2] = 32'h20;
        wdata[2] = 32'h12345678;
        @(posedge clk);
        #1;
        req[2] = 1'b0;
        rst[2] = 1'b1;
        @(negedge clk);
        chk("abort_no_done_c1", 32'(done[2]), 32'd0);
        @(posedge clk);
        #1;
        rst[2] = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(ready[2]), 32'd1);
        chk("abort_err", 32'(err[2]), 32'd0);
        chk("abort_rdata", rdata[2], 32'd0);
        exp_rdata[2] = '0;
        dones = 0;
        repeat (5) begin
            @(negedge clk);
            if (done[2] !== 1'b0) dones++;
        end
        chk("abort_no_late_done", 32'(dones), 32'd0);
        do_op(2, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        chk("abort_prestore_value", rdata[2], 32'hA5A5A5A5);

        // Randomized traffic against the reference model
        rand_run(0, 60);
        rand_run(1, 40);
        rand_run(2, 30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
